// File: rtl/tick_period_checker_pkg.sv
// rtl/tick_period_checker_pkg.sv - shared state encoding and defaults for the tick period checker
package tick_period_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // The upstream counter wraps every COUNTER_M cycles, so that is the expected tick spacing.
  localparam int COUNTER_M      = 7;
  localparam int DEF_EXP_PERIOD = COUNTER_M;
  localparam int DEF_TICK_PHASE = 4;

  function automatic logic [7:0] sat_add_err(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/tick_period_checker_edge_detect.sv
// rtl/tick_period_checker_edge_detect.sv - rising-edge detector turning tick_in levels into one-cycle events
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic ev
);

  logic tick_d_q;
  logic tick_d_d;

  always_comb begin
    tick_d_d = tick_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d_q <= 1'b0;
    end else begin
      tick_d_q <= tick_d_d;
    end
  end

  assign ev = tick_in & ~tick_d_q;

endmodule

// File: rtl/tick_period_checker.sv
// rtl/tick_period_checker.sv - measures tick spacing, checks period and phase, tracks lock and errors
module tick_period_checker
  import tick_period_checker_pkg::*;
#(
  parameter int W          = 8,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TICK_PHASE = DEF_TICK_PHASE,
  parameter int LOCK_N     = 3,
  parameter int MAX_GAP    = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         err_clr,
  input  logic         tick_in,
  input  logic [2:0]   count_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         mismatch,
  output logic         phase_err,
  output logic         timeout,
  output logic         locked,
  output logic [7:0]   err_count
);

  localparam int RW = $clog2(LOCK_N + 1);

  logic ev;

  tick_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .ev      (ev)
  );

  state_t         state_q, state_d;
  logic [W-1:0]   gap_q, gap_d;
  logic [RW-1:0]  run_q, run_d;
  logic [W-1:0]   period_q, period_d;
  logic           period_valid_q, period_valid_d;
  logic           mismatch_q, mismatch_d;
  logic           phase_err_q, phase_err_d;
  logic           timeout_q, timeout_d;
  logic           locked_q, locked_d;
  logic [7:0]     err_count_q, err_count_d;
  logic [1:0]     err_inc;

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    run_d          = run_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    mismatch_d     = 1'b0;
    phase_err_d    = 1'b0;
    timeout_d      = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      gap_d   = '0;
      run_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gap_d = '0;
          // The first tick only opens the measurement window.
          if (ev) begin
            state_d = ST_MEASURE;
            gap_d   = W'(1);
          end
        end
        default: begin
          if (ev) begin
            gap_d          = W'(1);
            period_d       = gap_q;
            period_valid_d = 1'b1;
            mismatch_d     = (gap_q != W'(EXP_PERIOD));
            phase_err_d    = (count_in != 3'(TICK_PHASE));
            if (mismatch_d || phase_err_d) begin
              run_d   = '0;
              state_d = ST_MEASURE;
            end else if (state_q == ST_MEASURE) begin
              run_d = run_q + RW'(1);
              if (run_d == RW'(LOCK_N)) begin
                state_d = ST_LOCKED;
              end
            end
          end else if (gap_q == W'(MAX_GAP - 1)) begin
            timeout_d = 1'b1;
            run_d     = '0;
            gap_d     = '0;
            state_d   = ST_IDLE;
          end else if (gap_q != W'(MAX_GAP)) begin
            gap_d = gap_q + W'(1);
          end
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    err_inc = {1'b0, mismatch_d} + {1'b0, phase_err_d} + {1'b0, timeout_d};
    if (err_clr) begin
      err_count_d = '0;
    end else begin
      err_count_d = sat_add_err(err_count_q, err_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      gap_q          <= '0;
      run_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      mismatch_q     <= 1'b0;
      phase_err_q    <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      run_q          <= run_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      mismatch_q     <= mismatch_d;
      phase_err_q    <= phase_err_d;
      timeout_q      <= timeout_d;
      locked_q       <= locked_d;
      err_count_q    <= err_count_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign mismatch     = mismatch_q;
  assign phase_err    = phase_err_q;
  assign timeout      = timeout_q;
  assign locked       = locked_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_tick_period_checker.sv
// tb/tb_tick_period_checker.sv - self-checking bench for tick_period_checker
module tb_tick_period_checker;

  localparam int W       = 8;
  localparam int EXP     = 7;
  localparam int PH      = 4;
  localparam int LOCK_N  = 3;
  localparam int MAX_GAP = 20;

  logic         clk = 1'b0;
  logic         reset, enable, err_clr, tick_in;
  logic [2:0]   count_in;
  logic [W-1:0] period;
  logic         period_valid, mismatch, phase_err, timeout, locked;
  logic [7:0]   err_count;

  tick_period_checker #(
    .W(W), .EXP_PERIOD(EXP), .TICK_PHASE(PH), .LOCK_N(LOCK_N), .MAX_GAP(MAX_GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .err_clr      (err_clr),
    .tick_in      (tick_in),
    .count_in     (count_in),
    .period       (period),
    .period_valid (period_valid),
    .mismatch     (mismatch),
    .phase_err    (phase_err),
    .timeout      (timeout),
    .locked       (locked),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pv_cnt   = 0;

  // Model state: time-stamped events rather than a gap counter.
  bit m_prev, m_active, m_locked;
  int m_last, m_run;
  int e_period, e_err;
  bit e_pv, e_mm, e_pe, e_to;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit ev;
    int gapv;
    cyc++;
    e_pv = 0; e_mm = 0; e_pe = 0; e_to = 0;
    if (reset) begin
      m_prev = 0; m_active = 0; m_locked = 0; m_run = 0;
      e_period = 0; e_err = 0;
    end else begin
      ev = tick_in && !m_prev;
      m_prev = tick_in;
      if (!enable) begin
        m_active = 0; m_run = 0; m_locked = 0;
      end else if (!m_active) begin
        if (ev) begin
          m_active = 1;
          m_last = cyc;
        end
      end else begin
        gapv = cyc - m_last;
        if (ev) begin
          e_period = gapv;
          e_pv = 1;
          e_mm = (gapv != EXP);
          e_pe = (count_in != 3'(PH));
          if (e_mm || e_pe) begin
            m_run = 0; m_locked = 0;
          end else begin
            m_run++;
            if (m_run >= LOCK_N) m_locked = 1;
          end
          m_last = cyc;
        end else if (gapv == MAX_GAP - 1) begin
          e_to = 1; m_active = 0; m_run = 0; m_locked = 0;
        end
      end
      if (err_clr) e_err = 0;
      else begin
        e_err = e_err + int'(e_mm) + int'(e_pe) + int'(e_to);
        if (e_err > 255) e_err = 255;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("period", period, e_period);
      chk("period_valid", period_valid, e_pv);
      chk("mismatch", mismatch, e_mm);
      chk("phase_err", phase_err, e_pe);
      chk("timeout", timeout, e_to);
      chk("locked", locked, m_locked);
      chk("err_count", err_count, e_err);
      if (period_valid === 1'b1) pv_cnt++;
    end
  end

  task automatic cyc1(input bit t, input logic [2:0] c, input bit clr);
    tick_in  = t;
    count_in = c;
    err_clr  = clr;
    @(negedge clk);
  endtask

  // One tick event followed by len-1 further cycles; len sets the gap to the next tick.
  task automatic tick_gap(input int len, input logic [2:0] c, input int width, input bit clr);
    for (int i = 0; i < len; i++) cyc1(i < width, c, (i == 0) && clr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int p0;
    reset = 1; enable = 0; err_clr = 0; tick_in = 0; count_in = 0;
    repeat (3) cyc1(0, 0, 0);
    #1;
    chk("rst_period", period, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_timeout", timeout, 0);

    reset = 0; enable = 1;
    repeat (2) cyc1(0, 3'(PH), 0);

    // Clean 7-cycle ticks reach lock after the fourth tick.
    p0 = pv_cnt;
    repeat (4) tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t1_period", period, 7);
    chk("t1_locked", locked, 1);
    chk("t1_err", err_count, 0);
    chk("t1_pv_count", pv_cnt - p0, 3);

    // One short gap drops lock, three good gaps regain it.
    tick_gap(6, 3'(PH), 1, 0);
    tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t2_period", period, 6);
    chk("t2_locked", locked, 0);
    chk("t2_err", err_count, 1);
    repeat (3) tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t2_relock", locked, 1);

    // Wrong phase on a correctly spaced tick.
    tick_gap(7, 3'd3, 1, 0);
    #1;
    chk("t3_period", period, 7);
    chk("t3_locked", locked, 0);
    chk("t3_err", err_count, 2);
    repeat (3) tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t3_relock", locked, 1);

    // Missing ticks time out; the next tick only restarts timing.
    repeat (25) cyc1(0, 3'(PH), 0);
    #1;
    chk("t4_locked", locked, 0);
    chk("t4_err", err_count, 3);
    p0 = pv_cnt;
    tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t4_no_pv", pv_cnt - p0, 0);
    tick_gap(7, 3'(PH), 1, 0);
    #1;
    chk("t4_pv_after", pv_cnt - p0, 1);
    chk("t4_period", period, 7);

    // Wide tick pulses count as one event each.
    repeat (4) tick_gap(7, 3'(PH), 3, 0);
    #1;
    chk("t5_period", period, 7);
    chk("t5_locked", locked, 1);
    chk("t5_err", err_count, 3);

    enable = 0;
    repeat (3) cyc1(0, 3'(PH), 0);
    #1;
    chk("en_locked", locked, 0);
    chk("en_period_hold", period, 7);
    chk("en_err_hold", err_count, 3);
    enable = 1;

    // Saturate the error counter, then clear it against a simultaneous mismatch.
    repeat (260) tick_gap(5, 3'(PH), 1, 0);
    #1;
    chk("t6_sat", err_count, 255);
    chk("t6_period", period, 5);
    tick_gap(5, 3'(PH), 1, 1);
    #1;
    chk("t6_clr", err_count, 0);
    tick_gap(3, 3'(PH), 1, 0);
    #1;
    chk("t6_err_after", err_count, 1);
    chk("t6_period_pre_rst", period, 5);
    reset = 1;
    cyc1(0, 3'(PH), 0);
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_pv", period_valid, 0);
    reset = 0;
    repeat (3) cyc1(0, 3'(PH), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
